// File: rtl/llc_mem_req_queue.sv
// llc_mem_req_queue: in-order memory request queue between the LLC core and
// the memory NoC plane, with read-credit throttling and a fill response buffer.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   core_req_*            core request in (valid/ready, hwrite/hsize/hprot/addr/line)
//   mem_req_*             head-of-queue request out to the NoC (valid/ready + fields)
//   mem_rsp_*             fill data in from memory (valid/ready/line)
//   core_rsp_*            buffered fill data out to the core (valid/ready/line)
//   rd_outstanding        reads issued to memory and not yet taken by the core
//   idle                  nothing queued, buffered or outstanding
//   err_unexp_rsp         sticky: fill arrived with no read outstanding
module llc_mem_req_queue #(
   parameter int unsigned LINE_ADDR_BITS     = 28,
   parameter int unsigned LINE_BITS          = 128,
   parameter int unsigned REQ_DEPTH          = 4,
   parameter int unsigned MAX_RD_OUTSTANDING = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      core_req_valid,
   output logic                      core_req_ready,
   input  logic                      core_req_hwrite,
   input  logic [2:0]                core_req_hsize,
   input  logic [1:0]                core_req_hprot,
   input  logic [LINE_ADDR_BITS-1:0] core_req_addr,
   input  logic [LINE_BITS-1:0]      core_req_line,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_hwrite,
   output logic [2:0]                mem_req_hsize,
   output logic [1:0]                mem_req_hprot,
   output logic [LINE_ADDR_BITS-1:0] mem_req_addr,
   output logic [LINE_BITS-1:0]      mem_req_line,
   input  logic                      mem_rsp_valid,
   output logic                      mem_rsp_ready,
   input  logic [LINE_BITS-1:0]      mem_rsp_line,
   output logic                      core_rsp_valid,
   input  logic                      core_rsp_ready,
   output logic [LINE_BITS-1:0]      core_rsp_line,
   output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0] rd_outstanding,
   output logic                      idle,
   output logic                      err_unexp_rsp
);

   localparam int unsigned PW  = $clog2(REQ_DEPTH);
   localparam int unsigned CW  = $clog2(REQ_DEPTH + 1);
   localparam int unsigned RW  = $clog2(MAX_RD_OUTSTANDING + 1);
   localparam int unsigned RPW =
      (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;

   localparam logic [CW-1:0]  DEPTH_C = CW'(REQ_DEPTH);
   localparam logic [RW-1:0]  MAX_C   = RW'(MAX_RD_OUTSTANDING);
   localparam logic [RPW-1:0] RLAST_C = RPW'(MAX_RD_OUTSTANDING - 1);

   typedef struct packed {
      logic                      hwrite;
      logic [2:0]                hsize;
      logic [1:0]                hprot;
      logic [LINE_ADDR_BITS-1:0] addr;
      logic [LINE_BITS-1:0]      line;
   } req_t;

   // request queue state
   req_t            req_mem_q [REQ_DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            req_rdy_q, req_rdy_d;

   // read credit / response buffer state
   logic [RW-1:0]   rd_q, rd_d;
   logic [LINE_BITS-1:0] rsp_mem_q [MAX_RD_OUTSTANDING];
   logic [RPW-1:0]  rsp_head_q, rsp_head_d;
   logic [RPW-1:0]  rsp_tail_q, rsp_tail_d;
   logic [RW-1:0]   rsp_cnt_q, rsp_cnt_d;

   logic            idle_q, idle_d;
   logic            err_q, err_d;

   req_t            req_in;
   req_t            head;
   logic            push, pop, rd_issue;
   logic            rsp_rdy, rsp_acc, rsp_unexp, rsp_push;
   logic            deliver, rd_ret;

   assign req_in = '{
      hwrite: core_req_hwrite,
      hsize:  core_req_hsize,
      hprot:  core_req_hprot,
      addr:   core_req_addr,
      line:   core_req_line
   };

   assign head = req_mem_q[head_q];

   // A read at the head waits for a credit; a write never does, but
   // strict ordering means anything behind a blocked read waits too.
   assign mem_req_valid  = (count_q != '0) &
                           (head.hwrite | (rd_q < MAX_C));
   assign mem_req_hwrite = head.hwrite;
   assign mem_req_hsize  = head.hsize;
   assign mem_req_hprot  = head.hprot;
   assign mem_req_addr   = head.addr;
   assign mem_req_line   = head.line;

   assign core_req_ready = req_rdy_q;

   assign push     = core_req_valid & req_rdy_q;
   assign pop      = mem_req_valid & mem_req_ready;
   assign rd_issue = pop & ~head.hwrite;

   // A fill with nothing outstanding is swallowed; since every buffered
   // line holds a credit, rd_q==0 implies the buffer is empty and ready.
   assign rsp_rdy   = rsp_cnt_q < MAX_C;
   assign rsp_acc   = mem_rsp_valid & rsp_rdy;
   assign rsp_unexp = rsp_acc & (rd_q == '0);
   assign rsp_push  = rsp_acc & ~rsp_unexp;

   assign core_rsp_valid = rsp_cnt_q != '0;
   assign core_rsp_line  = rsp_mem_q[rsp_head_q];
   assign deliver        = core_rsp_valid & core_rsp_ready;
   assign rd_ret         = deliver & (rd_q != '0);

   assign mem_rsp_ready  = rsp_rdy;
   assign rd_outstanding = rd_q;
   assign idle           = idle_q;
   assign err_unexp_rsp  = err_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Registered from the next count, so a pop in a full cycle
      // cannot reopen the door in that same cycle.
      req_rdy_d = count_d < DEPTH_C;
   end

   always_comb begin
      unique case ({rd_issue, rd_ret})
         2'b10:   rd_d = rd_q + RW'(1);
         2'b01:   rd_d = rd_q - RW'(1);
         default: rd_d = rd_q;
      endcase
      rsp_head_d = rsp_head_q;
      rsp_tail_d = rsp_tail_q;
      if (deliver) begin
         rsp_head_d = (rsp_head_q == RLAST_C) ? '0 :
                      rsp_head_q + RPW'(1);
      end
      if (rsp_push) begin
         rsp_tail_d = (rsp_tail_q == RLAST_C) ? '0 :
                      rsp_tail_q + RPW'(1);
      end
      unique case ({rsp_push, deliver})
         2'b10:   rsp_cnt_d = rsp_cnt_q + RW'(1);
         2'b01:   rsp_cnt_d = rsp_cnt_q - RW'(1);
         default: rsp_cnt_d = rsp_cnt_q;
      endcase
      err_d  = err_q | rsp_unexp;
      idle_d = (count_d == '0) & (rd_d == '0) &
               (rsp_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         req_rdy_q  <= 1'b1;
         rd_q       <= '0;
         rsp_head_q <= '0;
         rsp_tail_q <= '0;
         rsp_cnt_q  <= '0;
         idle_q     <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         req_rdy_q  <= req_rdy_d;
         rd_q       <= rd_d;
         rsp_head_q <= rsp_head_d;
         rsp_tail_q <= rsp_tail_d;
         rsp_cnt_q  <= rsp_cnt_d;
         idle_q     <= idle_d;
         err_q      <= err_d;
      end
   end

   // Storage is cleared so the head fields read as zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REQ_DEPTH; i++) begin
            req_mem_q[i] <= '0;
         end
      end else if (push) begin
         req_mem_q[tail_q] <= req_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_RD_OUTSTANDING; i++) begin
            rsp_mem_q[i] <= '0;
         end
      end else if (rsp_push) begin
         rsp_mem_q[rsp_tail_q] <= mem_rsp_line;
      end
   end

   a_count_bound: assert property (
      @(posedge clk) disable iff (!rst) count_q <= DEPTH_C);

   a_rd_bound: assert property (
      @(posedge clk) disable iff (!rst) rd_q <= MAX_C);

   a_rsp_bound: assert property (
      @(posedge clk) disable iff (!rst) rsp_cnt_q <= MAX_C);

   a_req_stable: assert property (
      @(posedge clk) disable iff (!rst)
      (mem_req_valid && !mem_req_ready) |=>
      (mem_req_valid && $stable(head)));

endmodule

// File: tb/tb_llc_mem_req_queue.sv
// Bench for llc_mem_req_queue: queue/credit reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_llc_mem_req_queue;

   localparam int AW    = 28;
   localparam int LW    = 128;
   localparam int DEPTH = 4;
   localparam int MAXR  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            core_req_valid;
   logic            core_req_ready;
   logic            core_req_hwrite;
   logic [2:0]      core_req_hsize;
   logic [1:0]      core_req_hprot;
   logic [AW-1:0]   core_req_addr;
   logic [LW-1:0]   core_req_line;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_hwrite;
   logic [2:0]      mem_req_hsize;
   logic [1:0]      mem_req_hprot;
   logic [AW-1:0]   mem_req_addr;
   logic [LW-1:0]   mem_req_line;
   logic            mem_rsp_valid;
   logic            mem_rsp_ready;
   logic [LW-1:0]   mem_rsp_line;
   logic            core_rsp_valid;
   logic            core_rsp_ready;
   logic [LW-1:0]   core_rsp_line;
   logic [1:0]      rd_outstanding;
   logic            idle;
   logic            err_unexp_rsp;

   llc_mem_req_queue #(
      .LINE_ADDR_BITS(AW),
      .LINE_BITS(LW),
      .REQ_DEPTH(DEPTH),
      .MAX_RD_OUTSTANDING(MAXR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .core_req_valid(core_req_valid),
      .core_req_ready(core_req_ready),
      .core_req_hwrite(core_req_hwrite),
      .core_req_hsize(core_req_hsize),
      .core_req_hprot(core_req_hprot),
      .core_req_addr(core_req_addr),
      .core_req_line(core_req_line),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_hwrite(mem_req_hwrite),
      .mem_req_hsize(mem_req_hsize),
      .mem_req_hprot(mem_req_hprot),
      .mem_req_addr(mem_req_addr),
      .mem_req_line(mem_req_line),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_line(mem_rsp_line),
      .core_rsp_valid(core_rsp_valid),
      .core_rsp_ready(core_rsp_ready),
      .core_rsp_line(core_rsp_line),
      .rd_outstanding(rd_outstanding),
      .idle(idle),
      .err_unexp_rsp(err_unexp_rsp)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // reference model: plain queues and a credit counter
   typedef struct packed {
      logic          hw;
      logic [2:0]    sz;
      logic [1:0]    pr;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
   } req_t;

   req_t          rq[$];
   logic [LW-1:0] rspq[$];
   int            m_rd  = 0;
   bit            m_err = 0;

   function automatic bit e_mvalid();
      if (rq.size() == 0) return 1'b0;
      return rq[0].hw || (m_rd < MAXR);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rq.delete();
         rspq.delete();
         m_rd  = 0;
         m_err = 0;
      end else begin
         bit   push, pop, acc, dlv;
         int   rd0;
         req_t nr;
         rd0  = m_rd;
         push = core_req_valid && (rq.size() < DEPTH);
         pop  = e_mvalid() && mem_req_ready;
         acc  = mem_rsp_valid && (rspq.size() < MAXR);
         dlv  = (rspq.size() != 0) && core_rsp_ready;
         nr   = '{core_req_hwrite, core_req_hsize, core_req_hprot,
                  core_req_addr, core_req_line};
         if (pop) begin
            if (!rq[0].hw) m_rd++;
            void'(rq.pop_front());
         end
         if (push) rq.push_back(nr);
         if (dlv) begin
            void'(rspq.pop_front());
            if (m_rd > 0) m_rd--;
         end
         if (acc) begin
            if (rd0 == 0) m_err = 1;
            else rspq.push_back(mem_rsp_line);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("core_req_ready", 128'(core_req_ready),
             128'(rq.size() < DEPTH));
         chk("mem_req_valid", 128'(mem_req_valid), 128'(e_mvalid()));
         if (e_mvalid()) begin
            chk("mem_req_hwrite", 128'(mem_req_hwrite), 128'(rq[0].hw));
            chk("mem_req_hsize", 128'(mem_req_hsize), 128'(rq[0].sz));
            chk("mem_req_hprot", 128'(mem_req_hprot), 128'(rq[0].pr));
            chk("mem_req_addr", 128'(mem_req_addr), 128'(rq[0].a));
            chk("mem_req_line", mem_req_line, rq[0].l);
         end
         chk("mem_rsp_ready", 128'(mem_rsp_ready),
             128'(rspq.size() < MAXR));
         chk("core_rsp_valid", 128'(core_rsp_valid),
             128'(rspq.size() != 0));
         if (rspq.size() != 0) begin
            chk("core_rsp_line", core_rsp_line, rspq[0]);
         end
         chk("rd_outstanding", 128'(rd_outstanding), 128'(m_rd));
         chk("idle", 128'(idle), 128'((rq.size() == 0) && (m_rd == 0)
             && (rspq.size() == 0)));
         chk("err_unexp_rsp", 128'(err_unexp_rsp), 128'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_req(input bit hw, input logic [AW-1:0] a,
                          input logic [LW-1:0] l);
      core_req_valid  = 1'b1;
      core_req_hwrite = hw;
      core_req_hsize  = 3'd4;
      core_req_hprot  = a[1:0];
      core_req_addr   = a;
      core_req_line   = l;
      tick();
      core_req_valid  = 1'b0;
   endtask

   task automatic drv_rsp(input logic [LW-1:0] l);
      mem_rsp_valid = 1'b1;
      mem_rsp_line  = l;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   function automatic logic [LW-1:0] mkline(input logic [31:0] s);
      return {s, ~s, s + 32'd1, s ^ 32'h5A5A_5A5A};
   endfunction

   logic [AW-1:0] a_w [4];
   logic [LW-1:0] d0, d1, d2, d3;

   initial begin
      rst             = 1'b0;
      core_req_valid  = 1'b0;
      core_req_hwrite = 1'b0;
      core_req_hsize  = '0;
      core_req_hprot  = '0;
      core_req_addr   = '0;
      core_req_line   = '0;
      mem_req_ready   = 1'b0;
      mem_rsp_valid   = 1'b0;
      mem_rsp_line    = '0;
      core_rsp_ready  = 1'b0;
      for (int i = 0; i < 4; i++) a_w[i] = AW'(28'h0001_000 + i);
      d0 = mkline(32'hD000_0000);
      d1 = mkline(32'hD111_1111);
      d2 = mkline(32'hD222_2222);
      d3 = mkline(32'hD333_3333);

      repeat (3) tick();
      chk_en = 1;
      chk("rst core_req_ready", 128'(core_req_ready), 128'(1));
      chk("rst idle", 128'(idle), 128'(1));
      chk("rst mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("rst rd_outstanding", 128'(rd_outstanding), 128'(0));
      tick();
      rst = 1'b1;
      tick();

      // fill queue with writes while the NoC stalls
      for (int i = 0; i < 4; i++) drv_req(1'b1, a_w[i], mkline(i));
      chk("full core_req_ready", 128'(core_req_ready), 128'(0));
      chk("full mem_req_valid", 128'(mem_req_valid), 128'(1));
      tick();
      chk("stall addr", 128'(mem_req_addr), 128'(a_w[0]));
      mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pop order addr", 128'(mem_req_addr), 128'(a_w[i]));
         tick();
      end
      mem_req_ready = 1'b0;
      chk("drained idle", 128'(idle), 128'(1));

      // read credit: third read and the write behind it block
      mem_req_ready = 1'b1;
      drv_req(1'b0, 28'h0002_000, '0);
      drv_req(1'b0, 28'h0002_001, '0);
      drv_req(1'b0, 28'h0002_002, '0);
      drv_req(1'b1, 28'h0002_003, d3);
      chk("credit rd_out", 128'(rd_outstanding), 128'(2));
      chk("credit blocked", 128'(mem_req_valid), 128'(0));
      tick();
      chk("credit still blocked", 128'(mem_req_valid), 128'(0));
      drv_rsp(d0);
      chk("fill visible", 128'(core_rsp_line), d0);
      chk("fill blocked still", 128'(mem_req_valid), 128'(0));
      core_rsp_ready = 1'b1;
      tick();
      core_rsp_ready = 1'b0;
      chk("credit back rd_out", 128'(rd_outstanding), 128'(1));
      chk("read unblocked", 128'(mem_req_addr), 128'(28'h0002_002));
      tick();
      chk("write follows", 128'(mem_req_addr), 128'(28'h0002_003));
      chk("write hwrite", 128'(mem_req_hwrite), 128'(1));
      tick();
      chk("queue empty", 128'(mem_req_valid), 128'(0));
      chk("rd_out two", 128'(rd_outstanding), 128'(2));
      mem_req_ready = 1'b0;

      // response backpressure
      chk("rsp room", 128'(mem_rsp_ready), 128'(1));
      drv_rsp(d1);
      drv_rsp(d2);
      chk("rsp full", 128'(mem_rsp_ready), 128'(0));
      chk("rsp order 0", core_rsp_line, d1);
      core_rsp_ready = 1'b1;
      tick();
      chk("rsp order 1", core_rsp_line, d2);
      chk("rsp rd_out 1", 128'(rd_outstanding), 128'(1));
      tick();
      core_rsp_ready = 1'b0;
      chk("rsp drained", 128'(core_rsp_valid), 128'(0));
      chk("rsp idle", 128'(idle), 128'(1));

      // simultaneous push and pop at count 2
      drv_req(1'b1, 28'h0003_000, d0);
      drv_req(1'b1, 28'h0003_001, d1);
      mem_req_ready = 1'b1;
      drv_req(1'b1, 28'h0003_002, d2);
      chk("pp ready", 128'(core_req_ready), 128'(1));
      chk("pp head", 128'(mem_req_addr), 128'(28'h0003_001));
      tick();
      chk("pp next", 128'(mem_req_addr), 128'(28'h0003_002));
      tick();
      chk("pp empty", 128'(mem_req_valid), 128'(0));

      // issue a read and deliver a fill in one cycle
      drv_req(1'b0, 28'h0004_000, '0);
      tick();
      mem_req_ready = 1'b0;
      drv_rsp(d2);
      drv_req(1'b0, 28'h0004_001, '0);
      chk("sim rd_out pre", 128'(rd_outstanding), 128'(1));
      chk("sim issue ready", 128'(mem_req_valid), 128'(1));
      mem_req_ready  = 1'b1;
      core_rsp_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      core_rsp_ready = 1'b0;
      chk("sim rd_out post", 128'(rd_outstanding), 128'(1));
      drv_rsp(d3);
      chk("sim fill", core_rsp_line, d3);
      core_rsp_ready = 1'b1;
      tick();
      core_rsp_ready = 1'b0;
      chk("sim idle", 128'(idle), 128'(1));

      // unexpected response
      chk("unexp rsp ready", 128'(mem_rsp_ready), 128'(1));
      drv_rsp(d1);
      chk("unexp dropped", 128'(core_rsp_valid), 128'(0));
      chk("unexp err", 128'(err_unexp_rsp), 128'(1));
      repeat (3) tick();
      chk("unexp sticky", 128'(err_unexp_rsp), 128'(1));

      // reset mid-traffic: 1 read out, 3 writes queued
      mem_req_ready = 1'b1;
      drv_req(1'b0, 28'h0005_000, '0);
      tick();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) drv_req(1'b1, a_w[i], mkline(i + 8));
      chk("mid rd_out", 128'(rd_outstanding), 128'(1));
      chk("mid busy", 128'(idle), 128'(0));
      rst = 1'b0;
      #1;
      chk("mid rst idle", 128'(idle), 128'(1));
      chk("mid rst ready", 128'(core_req_ready), 128'(1));
      chk("mid rst valid", 128'(mem_req_valid), 128'(0));
      chk("mid rst rd_out", 128'(rd_outstanding), 128'(0));
      chk("mid rst err", 128'(err_unexp_rsp), 128'(0));
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("post rst idle", 128'(idle), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
